// File: rtl/ycr1_imem_wb_resp.sv
// ycr1_imem_wb_resp
//   Terminates one IMEM router port and fetches instruction words over a
//   Wishbone classic master. One request outstanding, registered response,
//   back-to-back accept while presenting RDY_OK.
//
//   Parameters
//     YCR1_WB_TIMEOUT   bus cycles to wait for ack/err before RDY_ER (0 = off)
//     YCR1_WB_ADDR_OFS  added (wrapping) to the word address to form wb_adr_o
//
//   Ports
//     clk, rst_n                    clock, async active-low reset
//     imem_req/imem_cmd/imem_addr   request from router
//     imem_req_ack                  request accepted this cycle (combinational)
//     imem_rdata/imem_resp          registered response
//     wb_cyc_o/wb_stb_o/wb_we_o/wb_sel_o/wb_adr_o   Wishbone master outputs
//     wb_dat_i/wb_ack_i/wb_err_i    Wishbone slave returns
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no request in flight, ready to accept
//   BUS   | Wishbone read cycle active, waiting for ack/err/timeout
//   RESP  | response presented for exactly one cycle

`ifndef YCR1_IMEM_AWIDTH
`define YCR1_IMEM_AWIDTH 32
`endif
`ifndef YCR1_IMEM_DWIDTH
`define YCR1_IMEM_DWIDTH 32
`endif

module ycr1_imem_wb_resp #(
  parameter int                            YCR1_WB_TIMEOUT  = 255,
  parameter logic [`YCR1_IMEM_AWIDTH-1:0]  YCR1_WB_ADDR_OFS = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req_ack,
  input  logic                          imem_req,
  input  logic                          imem_cmd,
  input  logic [`YCR1_IMEM_AWIDTH-1:0]  imem_addr,
  output logic [`YCR1_IMEM_DWIDTH-1:0]  imem_rdata,
  output logic [1:0]                    imem_resp,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  output logic                          wb_we_o,
  output logic [3:0]                    wb_sel_o,
  output logic [`YCR1_IMEM_AWIDTH-1:0]  wb_adr_o,
  input  logic [`YCR1_IMEM_DWIDTH-1:0]  wb_dat_i,
  input  logic                          wb_ack_i,
  input  logic                          wb_err_i
);

  localparam int AW = `YCR1_IMEM_AWIDTH;
  localparam int DW = `YCR1_IMEM_DWIDTH;

  localparam logic       CMD_RD      = 1'b0;
  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_OK     = 2'b01;
  localparam logic [1:0] RESP_ER     = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_e;

  state_e          state, state_nxt;
  logic [1:0]      resp_r, resp_nxt;
  logic [DW-1:0]   rdata_r;
  logic [AW-3:0]   addr_hi_r;   // byte-offset bits are always zero for a real fetch
  logic [31:0]     tmo_cnt;
  logic            load_addr;
  logic            accept;
  logic            req_bad;
  logic            tmo_hit;

  assign accept  = imem_req & imem_req_ack;
  assign req_bad = (imem_cmd != CMD_RD) | (imem_addr[1:0] != 2'b00);
  // Fires on the cycle that would make the count reach the limit, so cyc is
  // high for exactly YCR1_WB_TIMEOUT cycles.
  assign tmo_hit = (YCR1_WB_TIMEOUT != 0) &&
                   ((tmo_cnt + 32'd1) == 32'(YCR1_WB_TIMEOUT));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    resp_nxt  = RESP_NOTRDY;
    load_addr = 1'b0;
    case (state)
      ST_IDLE, ST_RESP: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (req_bad) begin
            state_nxt = ST_RESP;
            resp_nxt  = RESP_ER;
          end else begin
            state_nxt = ST_BUS;
            load_addr = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (wb_err_i) begin
          state_nxt = ST_RESP;
          resp_nxt  = RESP_ER;
        end else if (wb_ack_i) begin
          state_nxt = ST_RESP;
          resp_nxt  = RESP_OK;
        end else if (tmo_hit) begin
          state_nxt = ST_RESP;
          resp_nxt  = RESP_ER;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    imem_req_ack = (state == ST_IDLE) ||
                   ((state == ST_RESP) && (resp_r == RESP_OK));
    wb_cyc_o     = (state == ST_BUS);
    wb_stb_o     = (state == ST_BUS);
    wb_we_o      = 1'b0;
    wb_sel_o     = 4'hF;
    wb_adr_o     = {addr_hi_r, 2'b00} + YCR1_WB_ADDR_OFS;
    imem_resp    = resp_r;
    imem_rdata   = rdata_r;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_r    <= RESP_NOTRDY;
      rdata_r   <= '0;
      addr_hi_r <= '0;
      tmo_cnt   <= '0;
    end else begin
      resp_r <= resp_nxt;
      if (load_addr) begin
        addr_hi_r <= imem_addr[AW-1:2];
      end
      if ((state == ST_BUS) && wb_ack_i && !wb_err_i) begin
        rdata_r <= wb_dat_i;
      end
      // held at zero outside BUS, which clears it on every BUS entry
      if (state == ST_BUS) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule
